// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Packs a byte stream (low byte first) into DSIZE-bit words and writes them to
// sequential addresses starting at 0, holding the core off while loading.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, load_len   begin a load of load_len words (accepted in IDLE only)
//   abort             abandon an in-progress load
//   byte_valid/_data  stream byte input, consumed when byte_ready is high
//   byte_ready        loader accepts a byte this cycle
//   wr_en/addr/data   single-cycle instruction memory write
//   cpu_hold          core held while a load is in progress
//   done              one-cycle pulse on load completion
//   len_err           sticky: last start asked for more than MAX_LINE_LENGTH words
module imem_loader #(
    parameter int unsigned ISIZE           = 16,
    parameter int unsigned DSIZE           = 16,
    parameter int unsigned MAX_LINE_LENGTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ISIZE-1:0] load_len,
    input  logic             abort,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             wr_en,
    output logic [ISIZE-1:0] wr_addr,
    output logic [DSIZE-1:0] wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             len_err
);

    localparam logic [ISIZE-1:0] MAX_LEN = ISIZE'(MAX_LINE_LENGTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_LO,
        S_RX_HI,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [ISIZE-1:0] len_q;
    logic [ISIZE-1:0] count_q;
    logic [7:0]       lo_q;

    logic             xfer_c;
    logic             last_c;
    logic [ISIZE-1:0] len_sel_c;

    assign xfer_c    = byte_valid && byte_ready;
    assign last_c    = (count_q + ISIZE'(1)) == len_q;
    assign len_sel_c = (load_len > MAX_LEN) ? MAX_LEN : load_len;

    // Next-state logic; abort wins over any same-cycle transfer or write
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len_sel_c == '0) ? S_DONE : S_RX_LO;
                end
            end
            S_RX_LO: begin
                if (abort)       state_nxt = S_IDLE;
                else if (xfer_c) state_nxt = S_RX_HI;
            end
            S_RX_HI: begin
                if (abort)       state_nxt = S_IDLE;
                else if (xfer_c) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (abort)       state_nxt = S_IDLE;
                else if (last_c) state_nxt = S_DONE;
                else             state_nxt = S_RX_LO;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs (outputs decoded from next state)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            count_q    <= '0;
            lo_q       <= '0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            byte_ready <= (state_nxt == S_RX_LO) || (state_nxt == S_RX_HI);
            wr_en      <= (state_nxt == S_WRITE);
            cpu_hold   <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_DONE);

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q   <= len_sel_c;
                        len_err <= (load_len > MAX_LEN);
                        wr_addr <= '0;
                        count_q <= '0;
                    end
                end
                S_RX_LO: begin
                    if (!abort && xfer_c) lo_q <= byte_data;
                end
                S_RX_HI: begin
                    if (!abort && xfer_c) wr_data <= DSIZE'({byte_data, lo_q});
                end
                S_WRITE: begin
                    if (!abort) begin
                        count_q <= count_q + ISIZE'(1);
                        // Hold the address on the final word so it never passes depth-1
                        if (!last_c) wr_addr <= wr_addr + ISIZE'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
